// File: rtl/frv_imem_responder.sv
// Instruction-memory responder for the core's imem_* fetch port: SRAM array, programmable wait states, error detection.
// Define FRV_IMEM_RESPONDER_WRITE_EN to allow strobed writes from the imem_* side (default: read-only).
module frv_imem_responder #(
    parameter logic [31:0] MEM_BASE    = 32'h8000_0000,
    parameter int unsigned MEM_DEPTH   = 1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                         g_clk,
    input  logic                         g_reset,
    input  logic                         imem_cen,
    input  logic                         imem_wen,
    input  logic [3:0]                   imem_strb,
    input  logic [31:0]                  imem_addr,
    input  logic [31:0]                  imem_wdata,
    output logic                         imem_stall,
    output logic                         imem_error,
    output logic [31:0]                  imem_rdata,
    input  logic                         ld_en,
    input  logic [$clog2(MEM_DEPTH)-1:0] ld_addr,
    input  logic [31:0]                  ld_data
);

    localparam int unsigned AW        = $clog2(MEM_DEPTH);
    localparam int unsigned WCNT_W    = 4;
    localparam logic [WCNT_W-1:0] WCNT_INIT = WCNT_W'(WAIT_CYCLES);
    localparam logic [32:0] MEM_LO    = 33'(MEM_BASE);
    localparam logic [32:0] MEM_HI    = 33'(MEM_BASE) + 33'(MEM_DEPTH) * 33'd4;

`ifdef FRV_IMEM_RESPONDER_WRITE_EN
    localparam logic WRITE_EN = 1'b1;
`else
    localparam logic WRITE_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [31:0]         addr_q;
    logic [31:0]         wdata_q;
    logic                wen_q;
    logic [3:0]          strb_q;
    logic [AW-1:0]       idx_q;
    logic                err_q;
    logic [31:0]         rdata_q, rdata_d;
    logic                error_q, error_d;
    logic                req_take;
    logic                mem_we;
    logic                req_err;
    logic [AW-1:0]       req_idx;

    logic [31:0]         mem [MEM_DEPTH];

    // Request decode: word index and access fault for the address on the bus
    always_comb begin
        req_idx = AW'((imem_addr - MEM_BASE) >> 2);
        req_err = (imem_addr[1:0] != 2'b00)
               || ({1'b0, imem_addr} <  MEM_LO)
               || ({1'b0, imem_addr} >= MEM_HI)
               || (imem_wen && !WRITE_EN);
    end

    // Next-state, wait counter and completion data
    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        rdata_d  = 32'h0;
        error_d  = 1'b0;
        req_take = 1'b0;
        mem_we   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (imem_cen) begin
                    state_d  = ST_WAIT;
                    wcnt_d   = WCNT_INIT;
                    req_take = 1'b1;
                end
            end
            ST_WAIT: begin
                wcnt_d = (wcnt_q == '0) ? '0 : wcnt_q - WCNT_W'(1);
                if (!imem_cen) begin
                    state_d = ST_IDLE;
                end else if (wcnt_d == '0) begin
                    state_d = ST_RESP;
                    error_d = err_q;
                    rdata_d = err_q ? 32'h0 : mem[idx_q];
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                mem_we  = imem_cen && wen_q && !err_q && WRITE_EN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state_q <= ST_IDLE;
            wcnt_q  <= '0;
            rdata_q <= 32'h0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
        end
    end

    // Latched request fields; authoritative for the whole transaction
    always_ff @(posedge g_clk) begin
        if (req_take) begin
            addr_q  <= imem_addr;
            wdata_q <= imem_wdata;
            wen_q   <= imem_wen;
            strb_q  <= imem_strb;
            idx_q   <= req_idx;
            err_q   <= req_err;
        end
    end

    // Array: strobed write in RESP, backdoor load issued last so it wins a collision
    always_ff @(posedge g_clk) begin
        if (mem_we && !g_reset) begin
            for (int i = 0; i < 4; i++) begin
                if (strb_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

    assign imem_stall = imem_cen && (g_reset || (state_q != ST_RESP));
    assign imem_error = error_q;
    assign imem_rdata = rdata_q;

    // The initiator must hold its request while a transaction is pending
    a_req_stable: assert property (@(posedge g_clk) disable iff (g_reset)
        ((state_q != ST_IDLE) && imem_cen) |->
            ((imem_addr == addr_q) && (!wen_q || (imem_wdata == wdata_q))));

endmodule

// File: tb/tb_frv_imem_responder.sv
// Directed bench for frv_imem_responder (WAIT_CYCLES=2, MEM_DEPTH=1024); expectations follow FRV_IMEM_RESPONDER_WRITE_EN.
module tb_frv_imem_responder;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned WAITC = 2;
    localparam int unsigned STALL_EXP = WAITC + 1;

`ifdef FRV_IMEM_RESPONDER_WRITE_EN
    localparam logic WE = 1'b1;
`else
    localparam logic WE = 1'b0;
`endif

    logic        g_clk;
    logic        g_reset;
    logic        imem_cen;
    logic        imem_wen;
    logic [3:0]  imem_strb;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        imem_stall;
    logic        imem_error;
    logic [31:0] imem_rdata;
    logic        ld_en;
    logic [9:0]  ld_addr;
    logic [31:0] ld_data;

    int total = 0;
    int bad   = 0;

    frv_imem_responder #(
        .MEM_BASE    (BASE),
        .MEM_DEPTH   (DEPTH),
        .WAIT_CYCLES (WAITC)
    ) dut (
        .g_clk      (g_clk),
        .g_reset    (g_reset),
        .imem_cen   (imem_cen),
        .imem_wen   (imem_wen),
        .imem_strb  (imem_strb),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .imem_stall (imem_stall),
        .imem_error (imem_error),
        .imem_rdata (imem_rdata),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic backdoor(input logic [9:0] a, input logic [31:0] d);
        @(negedge g_clk);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(negedge g_clk);
        ld_en   = 1'b0;
    endtask

    // One complete transaction; cen held through the RESP edge
    task automatic access(input logic [31:0] a, input logic w, input logic [3:0] s,
                          input logic [31:0] d, output logic [31:0] rd,
                          output logic er, output int nst);
        @(negedge g_clk);
        imem_cen   = 1'b1;
        imem_wen   = w;
        imem_strb  = s;
        imem_addr  = a;
        imem_wdata = d;
        #1;
        nst = 0;
        while (imem_stall && nst < 20) begin
            nst++;
            @(negedge g_clk);
            #1;
        end
        if (nst >= 20) check("stall_timeout", 32'(nst), 32'(STALL_EXP));
        rd = imem_rdata;
        er = imem_error;
        @(posedge g_clk);
        #1;
        imem_cen = 1'b0;
        imem_wen = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          nst;
    logic [31:0] bad_addr [3];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        g_reset    = 1'b1;
        imem_cen   = 1'b0;
        imem_wen   = 1'b0;
        imem_strb  = 4'h0;
        imem_addr  = BASE;
        imem_wdata = 32'h0;
        ld_en      = 1'b0;
        ld_addr    = '0;
        ld_data    = 32'h0;

        // Reset state
        repeat (2) @(negedge g_clk);
        check("rst_stall_cen0", 32'(imem_stall), 32'd0);
        imem_cen = 1'b1;
        #1;
        check("rst_stall_cen1", 32'(imem_stall), 32'd1);
        check("rst_rdata", imem_rdata, 32'h0);
        check("rst_error", 32'(imem_error), 32'd0);
        imem_cen = 1'b0;
        @(negedge g_clk);
        g_reset = 1'b0;

        backdoor(10'd0,    32'h0000_0013);
        backdoor(10'd1,    32'h1122_3344);
        backdoor(10'd2,    32'hDEAD_BEEF);
        backdoor(10'd3,    32'h5566_7788);
        backdoor(10'd1023, 32'hCAFE_F00D);

        // Plain read of word 0
        access(BASE, 1'b0, 4'h0, 32'h0, rd, er, nst);
        check("rd0_stall", 32'(nst), 32'(STALL_EXP));
        check("rd0_rdata", rd, 32'h0000_0013);
        check("rd0_error", 32'(er), 32'd0);
        check("rd0_idle_rdata", imem_rdata, 32'h0);

        // Byte-lane write returns the pre-write word
        access(BASE + 32'h4, 1'b1, 4'b0010, 32'hAABB_CCDD, rd, er, nst);
        check("wr1_stall", 32'(nst), 32'(STALL_EXP));
        check("wr1_rdata", rd, WE ? 32'h1122_3344 : 32'h0);
        check("wr1_error", 32'(er), WE ? 32'd0 : 32'd1);
        access(BASE + 32'h4, 1'b0, 4'h0, 32'h0, rd, er, nst);
        check("rb1_rdata", rd, WE ? 32'h1122_CC44 : 32'h1122_3344);
        check("rb1_error", 32'(er), 32'd0);

        // Last word in range
        access(BASE + 32'hFFC, 1'b0, 4'h0, 32'h0, rd, er, nst);
        check("last_rdata", rd, 32'hCAFE_F00D);
        check("last_error", 32'(er), 32'd0);

        // Below base, one past the end, misaligned
        bad_addr[0] = 32'h7FFF_FFFC;
        bad_addr[1] = 32'h8000_1000;
        bad_addr[2] = 32'h8000_0002;
        for (int i = 0; i < 3; i++) begin
            access(bad_addr[i], 1'b0, 4'h0, 32'h0, rd, er, nst);
            check($sformatf("bad%0d_error", i), 32'(er), 32'd1);
            check($sformatf("bad%0d_rdata", i), rd, 32'h0);
            check($sformatf("bad%0d_stall", i), 32'(nst), 32'(STALL_EXP));
        end

        // Abandoned write: cen dropped in WAIT
        @(negedge g_clk);
        imem_cen   = 1'b1;
        imem_wen   = 1'b1;
        imem_strb  = 4'hF;
        imem_addr  = BASE + 32'h8;
        imem_wdata = 32'h0;
        @(negedge g_clk);
        check("ab_stall_wait", 32'(imem_stall), 32'd1);
        imem_cen = 1'b0;
        imem_wen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge g_clk);
            check($sformatf("ab_error_%0d", i), 32'(imem_error), 32'd0);
            check($sformatf("ab_rdata_%0d", i), imem_rdata, 32'h0);
        end
        access(BASE + 32'h8, 1'b0, 4'h0, 32'h0, rd, er, nst);
        check("ab_rb_stall", 32'(nst), 32'(STALL_EXP));
        check("ab_rb_rdata", rd, 32'hDEAD_BEEF);

        // Full-word write to word 0 (rejected when writes are compiled out)
        access(BASE, 1'b1, 4'hF, 32'h1234_5678, rd, er, nst);
        check("wr0_error", 32'(er), WE ? 32'd0 : 32'd1);
        check("wr0_rdata", rd, WE ? 32'h0000_0013 : 32'h0);
        access(BASE, 1'b0, 4'h0, 32'h0, rd, er, nst);
        check("rb0_rdata", rd, WE ? 32'h1234_5678 : 32'h0000_0013);

        // Reset during WAIT of a write discards it
        @(negedge g_clk);
        imem_cen   = 1'b1;
        imem_wen   = 1'b1;
        imem_strb  = 4'hF;
        imem_addr  = BASE + 32'hC;
        imem_wdata = 32'h0;
        @(negedge g_clk);
        g_reset = 1'b1;
        #1;
        check("rw_stall_in_rst", 32'(imem_stall), 32'd1);
        @(negedge g_clk);
        check("rw_stall_after", 32'(imem_stall), 32'd1);
        check("rw_rdata", imem_rdata, 32'h0);
        check("rw_error", 32'(imem_error), 32'd0);
        @(negedge g_clk);
        g_reset  = 1'b0;
        imem_cen = 1'b0;
        imem_wen = 1'b0;
        access(BASE + 32'hC, 1'b0, 4'h0, 32'h0, rd, er, nst);
        check("rw_rb_stall", 32'(nst), 32'(STALL_EXP));
        check("rw_rb_rdata", rd, 32'h5566_7788);
        check("rw_rb_error", 32'(er), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
